mandelbrot_frame_scheduler: RTL
===============================

Name: mandelbrot_frame_scheduler

Overview:
- Sequences one Mandelbrot frame. Walks pixel coordinates (x,y) over x_size × y_size and dispatches each pixel to one of NUM_ENG iteration engines.
- Buffers each engine's returned iteration count and arbitrates the results onto the single frame-RAM write port.
- Raises ovf when the frame is complete so the address counter and RAM switch to display readout.
- Sits between the mapper/engines and the RAM in the mandelbrot top level.

Parameters:
- NUM_ENG, 4, number of iteration engines (1..8).
- CW, 8, iteration-count width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  frame request; level-sampled in IDLE and DONE only.
- x_size  in  10  frame width in pixels; sampled on frame start.
- y_size  in  10  frame height in pixels; sampled on frame start.
- eng_start  out  NUM_ENG  one-hot, 1-cycle pulse; the indexed engine captures eng_x/eng_y.
- eng_x  out  10  dispatched pixel x.
- eng_y  out  10  dispatched pixel y.
- eng_done  in  NUM_ENG  1-cycle pulse per engine; result ready.
- eng_count  in  NUM_ENG*CW  per-engine iteration count; slice i = [i*CW +: CW], valid with eng_done[i].
- wr_en  out  1  RAM write strobe (drives RAM WRITE_EN path).
- wr_addr  out  20  {y[9:0], x[9:0]} of the result being written.
- wr_data  out  CW  iteration count being written.
- ovf  out  1  frame complete; high only in DONE.
- busy  out  1  high in DISPATCH or DRAIN.
- err  out  1  sticky protocol error flag.

Behaviour:
- All outputs are registered. While rst=0 (asynchronous), every output is 0, the FSM is IDLE, all slots are FREE, and the counters and rr pointers are 0.
- Top FSM:
  - IDLE: if en=1 and x_size≠0 and y_size≠0, latch the sizes, set cx=cy=0, and go to DISPATCH. A zero size keeps the FSM in IDLE.
  - DISPATCH: at most one dispatch per cycle. After dispatching (x_size-1, y_size-1), go to DRAIN.
  - DRAIN: no dispatch. When all slots are FREE, go to DONE.
  - DONE: ovf=1. When en=0, go to IDLE. en is ignored in DISPATCH and DRAIN; a frame always completes.
- Per-engine slot FSM (FREE → RUN → PEND → FREE):
  - Dispatch selects the first FREE slot at or after dispatch rr pointer dptr, wrapping. eng_start[i]=1 and eng_x/eng_y=(cx,cy) in the next cycle. The slot stores tag (cx,cy) and goes to RUN; dptr becomes i+1 mod NUM_ENG.
  - Coordinate advance: cx increments. When cx=x_size-1, cx wraps to 0 and cy increments.
  - eng_done[i] while slot i is RUN: capture eng_count slice i and go to PEND.
  - eng_done[i] while slot i is FREE or PEND: ignored, and err is set to 1 and stays set until reset.
- Writeback arbiter:
  - At most one grant per cycle, round-robin among PEND slots starting at wptr.
  - The granted slot produces wr_en=1 with wr_addr={tag_y,tag_x} and wr_data=count in the next cycle. The slot goes to FREE; wptr becomes grant+1.
- Latencies:
  - en sampled high in IDLE → first eng_start 2 cycles later.
  - eng_done at cycle t → wr_en earliest at t+2.
  - A slot freed by writeback is dispatchable the cycle after its grant; no same-cycle reuse.
- Simultaneous events: dispatch, engine completions and writeback all proceed in the same cycle on different slots. Multiple eng_done pulses in one cycle are all captured.
- Last write → DONE (ovf=1) 1 cycle after that wr_en.
- Each pixel is written exactly once per frame. x_size and y_size changes mid-frame have no effect.

Test Plan:
- Frame: x_size=4, y_size=2; engines pulse done 3 cycles after start with count=x+y → exactly 8 wr_en, addresses {0,0}..{1,3} each once, wr_data=y+x; ovf=1 one cycle after the 8th write and held until en=0.
- All 4 engines done in the same cycle → wr_en on 4 consecutive cycles in round-robin order from wptr; those slots receive no eng_start before their write.
- x_size=0, en=1 → stays IDLE; no eng_start, no wr_en, ovf=0, busy=0.
- rst low mid-DISPATCH → all outputs 0 immediately; after release with en=1, the first dispatch is (0,0).
- eng_done[2] pulsed while slot 2 is FREE → err=1 (sticky), no wr_en, frame still completes.
- x_size=640, y_size=480 with random engine latency 1..50 → 307200 unique writes, last dispatch (639,479), ovf asserted once.

Source files
------------

// File: rtl/mandelbrot_frame_scheduler.sv
// rtl/mandelbrot_frame_scheduler.sv - dispatches frame pixels to iteration engines and arbitrates results to frame RAM
module mandelbrot_frame_scheduler #(
   parameter int NUM_ENG = 4,
   parameter int CW      = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [9:0]            x_size,
   input  logic [9:0]            y_size,
   output logic [NUM_ENG-1:0]    eng_start,
   output logic [9:0]            eng_x,
   output logic [9:0]            eng_y,
   input  logic [NUM_ENG-1:0]    eng_done,
   input  logic [NUM_ENG*CW-1:0] eng_count,
   output logic                  wr_en,
   output logic [19:0]           wr_addr,
   output logic [CW-1:0]         wr_data,
   output logic                  ovf,
   output logic                  busy,
   output logic                  err
);
   localparam int PW = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

   typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_DRAIN, S_DONE} state_t;
   typedef enum logic [1:0] {SL_FREE, SL_RUN, SL_PEND} slot_t;

   state_t        state_q, state_d;
   logic [9:0]    xs_q, xs_d, ys_q, ys_d, cx_q, cx_d, cy_q, cy_d;
   logic [PW-1:0] dptr_q, dptr_d, wptr_q, wptr_d;
   slot_t         slot_q [NUM_ENG];
   slot_t         slot_d [NUM_ENG];
   logic [9:0]    tag_x_q [NUM_ENG];
   logic [9:0]    tag_x_d [NUM_ENG];
   logic [9:0]    tag_y_q [NUM_ENG];
   logic [9:0]    tag_y_d [NUM_ENG];
   logic [CW-1:0] cnt_q [NUM_ENG];
   logic [CW-1:0] cnt_d [NUM_ENG];

   logic [NUM_ENG-1:0] eng_start_q, eng_start_d;
   logic [9:0]         eng_x_q, eng_x_d, eng_y_q, eng_y_d;
   logic               wr_en_q, wr_en_d;
   logic [19:0]        wr_addr_q, wr_addr_d;
   logic [CW-1:0]      wr_data_q, wr_data_d;
   logic               ovf_q, ovf_d, busy_q, busy_d, err_q, err_d;

   logic          disp_ok, grant_ok, all_free, dispatch;
   logic [PW-1:0] disp_idx, grant_idx;

   function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NUM_ENG) s = s - NUM_ENG;
      return PW'(s);
   endfunction

   // Round-robin searches: free slot from dptr for dispatch, pending slot from wptr for writeback.
   always_comb begin
      disp_ok   = 1'b0;
      disp_idx  = '0;
      grant_ok  = 1'b0;
      grant_idx = '0;
      all_free  = 1'b1;
      for (int k = 0; k < NUM_ENG; k++) begin
         if (!disp_ok && slot_q[wrap_add(dptr_q, k)] == SL_FREE) begin
            disp_ok  = 1'b1;
            disp_idx = wrap_add(dptr_q, k);
         end
         if (!grant_ok && slot_q[wrap_add(wptr_q, k)] == SL_PEND) begin
            grant_ok  = 1'b1;
            grant_idx = wrap_add(wptr_q, k);
         end
         if (slot_q[k] != SL_FREE) all_free = 1'b0;
      end
   end

   always_comb begin
      state_d     = state_q;
      xs_d        = xs_q;
      ys_d        = ys_q;
      cx_d        = cx_q;
      cy_d        = cy_q;
      dptr_d      = dptr_q;
      wptr_d      = wptr_q;
      slot_d      = slot_q;
      tag_x_d     = tag_x_q;
      tag_y_d     = tag_y_q;
      cnt_d       = cnt_q;
      eng_start_d = '0;
      eng_x_d     = eng_x_q;
      eng_y_d     = eng_y_q;
      wr_en_d     = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      err_d       = err_q;
      dispatch    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (en && x_size != 10'd0 && y_size != 10'd0) begin
               xs_d    = x_size;
               ys_d    = y_size;
               cx_d    = 10'd0;
               cy_d    = 10'd0;
               state_d = S_DISPATCH;
            end
         end
         S_DISPATCH: begin
            if (disp_ok) begin
               dispatch = 1'b1;
               if (cx_q == xs_q - 10'd1) begin
                  cx_d = 10'd0;
                  cy_d = cy_q + 10'd1;
                  if (cy_q == ys_q - 10'd1) state_d = S_DRAIN;
               end else begin
                  cx_d = cx_q + 10'd1;
               end
            end
         end
         S_DRAIN: if (all_free) state_d = S_DONE;
         S_DONE:  if (!en) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (dispatch) begin
         eng_start_d[disp_idx] = 1'b1;
         eng_x_d               = cx_q;
         eng_y_d               = cy_q;
         slot_d[disp_idx]      = SL_RUN;
         tag_x_d[disp_idx]     = cx_q;
         tag_y_d[disp_idx]     = cy_q;
         dptr_d                = wrap_add(disp_idx, 1);
      end

      if (grant_ok) begin
         wr_en_d           = 1'b1;
         wr_addr_d         = {tag_y_q[grant_idx], tag_x_q[grant_idx]};
         wr_data_d         = cnt_q[grant_idx];
         slot_d[grant_idx] = SL_FREE;
         wptr_d            = wrap_add(grant_idx, 1);
      end

      // Completions never collide with dispatch or grant: those only touch FREE and PEND slots.
      for (int i = 0; i < NUM_ENG; i++) begin
         if (eng_done[i]) begin
            if (slot_q[i] == SL_RUN) begin
               slot_d[i] = SL_PEND;
               cnt_d[i]  = eng_count[i*CW +: CW];
            end else begin
               err_d = 1'b1;
            end
         end
      end

      ovf_d  = (state_d == S_DONE);
      busy_d = (state_d == S_DISPATCH) || (state_d == S_DRAIN);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         xs_q        <= '0;
         ys_q        <= '0;
         cx_q        <= '0;
         cy_q        <= '0;
         dptr_q      <= '0;
         wptr_q      <= '0;
         for (int i = 0; i < NUM_ENG; i++) begin
            slot_q[i]  <= SL_FREE;
            tag_x_q[i] <= '0;
            tag_y_q[i] <= '0;
            cnt_q[i]   <= '0;
         end
         eng_start_q <= '0;
         eng_x_q     <= '0;
         eng_y_q     <= '0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         ovf_q       <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         xs_q        <= xs_d;
         ys_q        <= ys_d;
         cx_q        <= cx_d;
         cy_q        <= cy_d;
         dptr_q      <= dptr_d;
         wptr_q      <= wptr_d;
         slot_q      <= slot_d;
         tag_x_q     <= tag_x_d;
         tag_y_q     <= tag_y_d;
         cnt_q       <= cnt_d;
         eng_start_q <= eng_start_d;
         eng_x_q     <= eng_x_d;
         eng_y_q     <= eng_y_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         ovf_q       <= ovf_d;
         busy_q      <= busy_d;
         err_q       <= err_d;
      end
   end

   assign eng_start = eng_start_q;
   assign eng_x     = eng_x_q;
   assign eng_y     = eng_y_q;
   assign wr_en     = wr_en_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign ovf       = ovf_q;
   assign busy      = busy_q;
   assign err       = err_q;

endmodule
